mantissa_swap_pipe: RTL and testbench

Pipelined, parametrised operand-ordering stage for the floating-point adder datapath, sitting between exponent alignment and the mantissa add/subtract unit. It accepts two signed operands (sign, exponent, mantissa), and orders them into a greater/less pair under a selectable ordering mode. It also produces swap, equality and effective-subtract flags. A two-stage valid/ready pipeline supports full-rate throughput and downstream backpressure.

---
 rtl/mantissa_swap_pipe.sv | 139 +++++++++++++
 tb/tb_mantissa_swap_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mantissa_swap_pipe.sv
// mantissa_swap_pipe: two-stage operand-ordering pipeline for the FP adder.
// S1 registers the operands, the mode and the key compare (lt/eq).
// S2 resolves the swap decision and registers the greater/less pair and flags.
//
// Handshake: a pair moves across a boundary on the cycle its valid and the
// receiver's ready are both high. S2 may load whenever it is empty or being
// drained this cycle; S1 may accept whenever it is empty or advancing into S2,
// so o_ready depends on i_ready and state only, never on i_valid.
module mantissa_swap_pipe #(
    parameter int SIZE_DATA = 28,
    parameter int SIZE_EXP  = 8,
    parameter bit CMP_EXP   = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [1:0]           i_mode,
    input  logic                 i_sign_A,
    input  logic                 i_sign_B,
    input  logic [SIZE_EXP-1:0]  i_exp_A,
    input  logic [SIZE_EXP-1:0]  i_exp_B,
    input  logic [SIZE_DATA-1:0] i_mantissa_A,
    input  logic [SIZE_DATA-1:0] i_mantissa_B,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_sign_greater,
    output logic [SIZE_EXP-1:0]  o_exp_greater,
    output logic [SIZE_DATA-1:0] o_mantissa_greater,
    output logic                 o_sign_less,
    output logic [SIZE_EXP-1:0]  o_exp_less,
    output logic [SIZE_DATA-1:0] o_mantissa_less,
    output logic                 o_swapped,
    output logic                 o_equal,
    output logic                 o_eff_sub
);

    localparam int KEY_W = SIZE_EXP + SIZE_DATA;

    typedef enum logic [1:0] {
        MODE_MAG      = 2'b00,
        MODE_PASS     = 2'b01,
        MODE_SWAP     = 2'b10,
        MODE_MAG_SIGN = 2'b11
    } mode_t;

    logic [KEY_W-1:0]     key_a, key_b;
    logic                 in_xfer, s2_load, s1_adv, swap;

    logic                 s1_valid;
    mode_t                s1_mode;
    logic                 s1_sign_a, s1_sign_b, s1_lt, s1_eq;
    logic [SIZE_EXP-1:0]  s1_exp_a, s1_exp_b;
    logic [SIZE_DATA-1:0] s1_mant_a, s1_mant_b;

    // Comparison key: exponent-qualified magnitude, or mantissa alone
    always_comb begin
        key_a = CMP_EXP ? {i_exp_A, i_mantissa_A} : {{SIZE_EXP{1'b0}}, i_mantissa_A};
        key_b = CMP_EXP ? {i_exp_B, i_mantissa_B} : {{SIZE_EXP{1'b0}}, i_mantissa_B};
    end

    // Pipeline flow control
    always_comb begin
        s2_load = ~o_valid | i_ready;
        s1_adv  = s1_valid & s2_load;
        o_ready = ~s1_valid | s2_load;
        in_xfer = i_valid & o_ready;
    end

    // S1: capture operands, mode and compare result on input transfer
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid  <= 1'b0;
            s1_mode   <= MODE_MAG;
            s1_sign_a <= 1'b0;
            s1_sign_b <= 1'b0;
            s1_exp_a  <= '0;
            s1_exp_b  <= '0;
            s1_mant_a <= '0;
            s1_mant_b <= '0;
            s1_lt     <= 1'b0;
            s1_eq     <= 1'b0;
        end else if (in_xfer) begin
            s1_valid  <= 1'b1;
            s1_mode   <= mode_t'(i_mode);
            s1_sign_a <= i_sign_A;
            s1_sign_b <= i_sign_B;
            s1_exp_a  <= i_exp_A;
            s1_exp_b  <= i_exp_B;
            s1_mant_a <= i_mantissa_A;
            s1_mant_b <= i_mantissa_B;
            s1_lt     <= key_a < key_b;
            s1_eq     <= key_a == key_b;
        end else if (s1_adv) begin
            s1_valid  <= 1'b0;
        end
    end

    // Swap decision from the registered compare and mode
    always_comb begin
        swap = 1'b0;
        case (s1_mode)
            MODE_MAG:  swap = s1_lt;
            MODE_PASS: swap = 1'b0;
            MODE_SWAP: swap = 1'b1;
            default:   swap = s1_lt | (s1_eq & s1_sign_a & ~s1_sign_b);
        endcase
    end

    // S2: route operands into greater/less slots and register the flags
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid            <= 1'b0;
            o_sign_greater     <= 1'b0;
            o_exp_greater      <= '0;
            o_mantissa_greater <= '0;
            o_sign_less        <= 1'b0;
            o_exp_less         <= '0;
            o_mantissa_less    <= '0;
            o_swapped          <= 1'b0;
            o_equal            <= 1'b0;
            o_eff_sub          <= 1'b0;
        end else if (s1_adv) begin
            o_valid            <= 1'b1;
            o_sign_greater     <= swap ? s1_sign_b : s1_sign_a;
            o_exp_greater      <= swap ? s1_exp_b  : s1_exp_a;
            o_mantissa_greater <= swap ? s1_mant_b : s1_mant_a;
            o_sign_less        <= swap ? s1_sign_a : s1_sign_b;
            o_exp_less         <= swap ? s1_exp_a  : s1_exp_b;
            o_mantissa_less    <= swap ? s1_mant_a : s1_mant_b;
            o_swapped          <= swap;
            o_equal            <= s1_eq;
            o_eff_sub          <= s1_sign_a ^ s1_sign_b;
        end else if (i_ready) begin
            o_valid            <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mantissa_swap_pipe.sv
// tb_mantissa_swap_pipe: directed vector table plus stall and reset sequences.
// Two instances share the inputs: one keyed on {exp, mantissa}, one on mantissa.
module tb_mantissa_swap_pipe;

    localparam int SD = 28;
    localparam int SE = 8;
    localparam int OP = 1 + SE + SD;
    localparam int W  = 2 * OP + 3;
    localparam int NV = 11;

    typedef struct packed {
        logic          sa;
        logic [SE-1:0] ea;
        logic [SD-1:0] ma;
        logic          sb;
        logic [SE-1:0] eb;
        logic [SD-1:0] mb;
        logic [1:0]    mode;
        logic          sw1;
        logic          eq1;
        logic          sw0;
        logic          eq0;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b1;
    logic [1:0]    i_mode = 2'b00;
    logic          sign_a = 1'b0, sign_b = 1'b0;
    logic [SE-1:0] exp_a = '0, exp_b = '0;
    logic [SD-1:0] mant_a = '0, mant_b = '0;

    logic          o_ready1, o_valid1, sg1, sl1, sw1, eq1, es1;
    logic [SE-1:0] eg1, el1;
    logic [SD-1:0] mg1, ml1;
    logic          o_ready0, o_valid0, sg0, sl0, sw0, eq0, es0;
    logic [SE-1:0] eg0, el0;
    logic [SD-1:0] mg0, ml0;

    logic [W-1:0]  out1, out0, held;
    logic          held_valid = 1'b0;
    logic [W-1:0]  exp_q1[$];
    logic [W-1:0]  exp_q0[$];
    vec_t          vecs[NV];
    int            total = 0;
    int            bad = 0;
    int            n_pop = 0;

    assign out1 = {sg1, eg1, mg1, sl1, el1, ml1, sw1, eq1, es1};
    assign out0 = {sg0, eg0, mg0, sl0, el0, ml0, sw0, eq0, es0};

    mantissa_swap_pipe #(.SIZE_DATA(SD), .SIZE_EXP(SE), .CMP_EXP(1'b1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready1),
        .i_mode(i_mode), .i_sign_A(sign_a), .i_sign_B(sign_b),
        .i_exp_A(exp_a), .i_exp_B(exp_b), .i_mantissa_A(mant_a), .i_mantissa_B(mant_b),
        .o_valid(o_valid1), .i_ready(i_ready),
        .o_sign_greater(sg1), .o_exp_greater(eg1), .o_mantissa_greater(mg1),
        .o_sign_less(sl1), .o_exp_less(el1), .o_mantissa_less(ml1),
        .o_swapped(sw1), .o_equal(eq1), .o_eff_sub(es1)
    );

    mantissa_swap_pipe #(.SIZE_DATA(SD), .SIZE_EXP(SE), .CMP_EXP(1'b0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready0),
        .i_mode(i_mode), .i_sign_A(sign_a), .i_sign_B(sign_b),
        .i_exp_A(exp_a), .i_exp_B(exp_b), .i_mantissa_A(mant_a), .i_mantissa_B(mant_b),
        .o_valid(o_valid0), .i_ready(i_ready),
        .o_sign_greater(sg0), .o_exp_greater(eg0), .o_mantissa_greater(mg0),
        .o_sign_less(sl0), .o_exp_less(el0), .o_mantissa_less(ml0),
        .o_swapped(sw0), .o_equal(eq0), .o_eff_sub(es0)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] make_exp(input vec_t v, input logic sw, input logic eq);
        logic [OP-1:0] a;
        logic [OP-1:0] b;
        a = {v.sa, v.ea, v.ma};
        b = {v.sb, v.eb, v.mb};
        return sw ? {b, a, sw, eq, v.sa ^ v.sb} : {a, b, sw, eq, v.sa ^ v.sb};
    endfunction

    // driver: present one pair (called at a falling edge)
    task automatic drive(input vec_t v);
        sign_a = v.sa; exp_a = v.ea; mant_a = v.ma;
        sign_b = v.sb; exp_b = v.eb; mant_b = v.mb;
        i_mode = v.mode;
        i_valid = 1'b1;
    endtask

    // one cycle: check ready, scoreboard outputs, record accepts, advance
    task automatic step(input vec_t v, output bit acc);
        #1;
        check1("o_ready_k1", o_ready1, i_ready | (exp_q1.size() < 2));
        check1("o_ready_k0", o_ready0, i_ready | (exp_q0.size() < 2));
        if (o_valid1) begin
            if (held_valid) check("hold_stable", out1, held);
            if (i_ready) begin
                if (exp_q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out_k1: got %0h expected none", out1);
                end else begin
                    check("out_k1", out1, exp_q1.pop_front());
                    n_pop++;
                end
                held_valid = 1'b0;
            end else begin
                held = out1;
                held_valid = 1'b1;
            end
        end
        if (o_valid0 && i_ready) begin
            if (exp_q0.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out_k0: got %0h expected none", out0);
            end else begin
                check("out_k0", out0, exp_q0.pop_front());
            end
        end
        acc = i_valid && o_ready1;
        if (acc) begin
            exp_q1.push_back(make_exp(v, v.sw1, v.eq1));
            exp_q0.push_back(make_exp(v, v.sw0, v.eq0));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(output int cycles);
        bit acc;
        i_valid = 1'b0;
        i_ready = 1'b1;
        cycles = 0;
        while ((exp_q1.size() != 0 || exp_q0.size() != 0) && cycles < 20) begin
            step(vecs[0], acc);
            cycles++;
        end
        check1("drain_empty", (exp_q1.size() == 0) && (exp_q0.size() == 0), 1'b1);
    endtask

    initial begin
        bit acc;
        int cyc;
        int k;
        int c;
        //            sa    ea     ma           sb    eb     mb           mode  sw1 eq1 sw0 eq0
        vecs[0]  = '{1'b0, 8'h80, 28'h0800000, 1'b1, 8'h81, 28'h0400000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h7F, 28'h0C00000, 1'b0, 8'h7F, 28'h0C00000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 8'h7F, 28'h0C00000, 1'b0, 8'h7F, 28'h0C00000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 8'hFF, 28'h0000001, 1'b0, 8'h00, 28'h0000002, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'h80, 28'h0800000, 1'b1, 8'h81, 28'h0400000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'h80, 28'h0800000, 1'b1, 8'h81, 28'h0400000, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h10, 28'h0000005, 1'b0, 8'h10, 28'h0000005, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 8'h10, 28'h0000005, 1'b1, 8'h10, 28'h0000005, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 8'h01, 28'h0000003, 1'b1, 8'h02, 28'h0000001, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h90, 28'hFFFFFFF, 1'b0, 8'h90, 28'hFFFFFFE, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h33, 28'h0ABCDEF, 1'b1, 8'h33, 28'h0ABCDEF, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1};

        // reset block
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check1("reset_o_valid", o_valid1, 1'b0);
        check1("reset_o_ready", o_ready1, 1'b1);
        check("reset_outputs", out1, '0);

        // latency of a single pair: visible after the second edge
        drive(vecs[0]);
        step(vecs[0], acc);
        check1("lat_accept", acc, 1'b1);
        i_valid = 1'b0;
        #1;
        check1("lat_edge1_valid", o_valid1, 1'b0);
        step(vecs[0], acc);
        #1;
        check1("lat_edge2_valid", o_valid1, 1'b1);
        drain(cyc);

        // full table streamed back to back with i_ready high
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
            check1("stream_valid", o_valid1, i >= 2);
            step(vecs[i], acc);
            check1("stream_accept", acc, 1'b1);
        end
        drain(cyc);
        check("stream_drain_cycles", W'(cyc), W'(2));

        // backpressure: six pairs, i_ready low on cycles 3..7
        k = 0;
        c = 0;
        n_pop = 0;
        while ((k < 6 || exp_q1.size() != 0) && c < 40) begin
            i_ready = !(c >= 3 && c <= 7);
            if (k < 6) drive(vecs[k]);
            else i_valid = 1'b0;
            step(vecs[k < 6 ? k : 0], acc);
            if (acc) k++;
            c++;
        end
        check("stall_accepted", W'(k), W'(6));
        check("stall_popped", W'(n_pop), W'(6));
        drain(cyc);

        // reset with two pairs held in flight
        i_ready = 1'b0;
        drive(vecs[1]);
        step(vecs[1], acc);
        drive(vecs[2]);
        step(vecs[2], acc);
        check("flight_count", W'(exp_q1.size()), W'(2));
        rst_n = 1'b0;
        drive(vecs[3]);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        exp_q1.delete();
        exp_q0.delete();
        held_valid = 1'b0;
        #1;
        check1("midrst_o_valid", o_valid1, 1'b0);
        check1("midrst_o_ready", o_ready1, 1'b1);
        check("midrst_outputs", out1, '0);
        for (int i = 0; i < 3; i++) step(vecs[0], acc);
        drive(vecs[8]);
        step(vecs[8], acc);
        check1("post_reset_accept", acc, 1'b1);
        drain(cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
